// File: rtl/uart_periph.sv
// APB-slave UART: 8N1 transmitter and receiver, each behind a small FWFT FIFO.
// Register map (PADDR[3:2]): 0 USR status, 1 reserved, 2 UTD tx push, 3 URD rx pop.
module uart_periph #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);

    localparam int unsigned BaudDivRaw = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned BaudDiv    = (BaudDivRaw == 0) ? 1 : BaudDivRaw;
    localparam int unsigned BaudW      = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       apb_access;
    logic       apb_rd;
    logic       apb_wr;
    logic [1:0] reg_sel;
    logic       usr_clr;
    logic       unused_apb;

    assign apb_access = PSEL & PENABLE;
    assign apb_rd     = apb_access & ~PWRITE;
    assign apb_wr     = apb_access & PWRITE;
    assign reg_sel    = PADDR[3:2];
    assign usr_clr    = apb_rd & (reg_sel == 2'd0);
    assign unused_apb = ^{PADDR[1:0], PWDATA[31:8]};

    // ------------------------------------------------------------------
    // Baud generator: free-running 16x oversample tick
    // ------------------------------------------------------------------
    logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
    logic             tick;

    // Tick on the last count, then wrap.
    always_comb begin
        tick       = (baud_cnt_q == BaudW'(BaudDiv - 1));
        baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    // Baud counter register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) baud_cnt_q <= '0;
        else         baud_cnt_q <= baud_cnt_d;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]   tx_mem [FIFO_DEPTH];
    logic [AddrW:0] tx_wr_q, tx_rd_q;
    logic         tx_empty, tx_full;
    logic [7:0]   tx_head;
    logic         tx_push_req, tx_push_ok, tx_pop;

    assign tx_empty    = (tx_wr_q == tx_rd_q);
    assign tx_full     = (tx_wr_q[AddrW] != tx_rd_q[AddrW]) &&
                         (tx_wr_q[AddrW-1:0] == tx_rd_q[AddrW-1:0]);
    assign tx_head     = tx_mem[tx_rd_q[AddrW-1:0]];
    assign tx_push_req = apb_wr & (reg_sel == 2'd2);
    // A pop on the same edge frees a slot, so a push to a full FIFO still lands.
    assign tx_push_ok  = tx_push_req & (~tx_full | tx_pop);

    // TX FIFO pointers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    // TX FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge PCLK) begin
        if (tx_push_ok) tx_mem[tx_wr_q[AddrW-1:0]] <= PWDATA[7:0];
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]   rx_mem [FIFO_DEPTH];
    logic [AddrW:0] rx_wr_q, rx_rd_q;
    logic         rx_empty, rx_full;
    logic [7:0]   rx_head;
    logic         rx_push_req, rx_push_ok, rx_pop;
    logic [7:0]   rx_push_data;

    assign rx_empty   = (rx_wr_q == rx_rd_q);
    assign rx_full    = (rx_wr_q[AddrW] != rx_rd_q[AddrW]) &&
                        (rx_wr_q[AddrW-1:0] == rx_rd_q[AddrW-1:0]);
    assign rx_head    = rx_mem[rx_rd_q[AddrW-1:0]];
    assign rx_pop     = apb_rd & (reg_sel == 2'd3) & ~rx_empty;
    assign rx_push_ok = rx_push_req & (~rx_full | rx_pop);

    // RX FIFO pointers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)     rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    // RX FIFO storage.
    always_ff @(posedge PCLK) begin
        if (rx_push_ok) rx_mem[rx_wr_q[AddrW-1:0]] <= rx_push_data;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_out_q, tx_out_d;

    // Next-state: every bit boundary lands on a baud tick, so each bit lasts 16 ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (tick && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_out_d   = 1'b0;
                    tx_tick_d  = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tick) begin
                    if (tx_tick_q == 4'd15) begin
                        tx_tick_d  = '0;
                        tx_bit_d   = '0;
                        tx_out_d   = tx_shift_q[0];
                        tx_state_d = TxData;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TxData: begin
                if (tick) begin
                    if (tx_tick_q == 4'd15) begin
                        tx_tick_d = '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_out_d   = 1'b1;
                            tx_state_d = TxStop;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_out_d   = tx_shift_q[1];
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TxStop: begin
                if (tick) begin
                    if (tx_tick_q == 4'd15) begin
                        tx_tick_d = '0;
                        // Chain straight into the next start bit: no idle gap.
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_head;
                            tx_out_d   = 1'b0;
                            tx_state_d = TxStart;
                        end else begin
                            tx_state_d = TxIdle;
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state register; reset forces the line idle-high at once.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            tx_state_q <= TxIdle;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign tx = tx_out_q;

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic       rx_meta_q, rx_sync_q;
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_ovf_set, rx_ferr_set;

    // Two-flop synchronizer for the asynchronous rx pin.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_push_data = rx_shift_q;

    // Next-state: confirm start at tick 8, then sample every 16 ticks (bit mid-points).
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        rx_ovf_set  = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (tick && !rx_sync_q) begin
                    rx_tick_d  = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (tick) begin
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d = '0;
                        rx_bit_d  = '0;
                        // A high line at mid-start was only a glitch.
                        rx_state_d = rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            RxData: begin
                if (tick) begin
                    if (rx_tick_q == 4'd15) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            RxStop: begin
                if (tick) begin
                    if (rx_tick_q == 4'd15) begin
                        rx_tick_d  = '0;
                        rx_state_d = RxIdle;
                        if (rx_sync_q) begin
                            rx_push_req = 1'b1;
                            // Same-edge CPU pop makes room, so only a true full drops.
                            if (rx_full && !rx_pop) rx_ovf_set = 1'b1;
                        end else begin
                            rx_ferr_set = 1'b1;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rx_state_q <= RxIdle;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status and APB read mux
    // ------------------------------------------------------------------
    logic ovf_q, ovf_d;
    logic ferr_q, ferr_d;
    logic [4:0] usr;

    // New events win over a same-edge clear so none is lost.
    always_comb begin
        ovf_d  = (ovf_q & ~usr_clr) | rx_ovf_set;
        ferr_d = (ferr_q & ~usr_clr) | rx_ferr_set;
    end

    // Sticky flag registers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    assign usr = {ferr_q, ovf_q, (tx_empty && (tx_state_q == TxIdle)), ~tx_full, ~rx_empty};

    // Zero-wait-state handshake; bus outputs held low while in reset.
    assign PREADY = apb_access & PRESET;

    // Read data from the addressed register during a read access phase, else zero.
    always_comb begin
        PRDATA = '0;
        if (apb_rd && PRESET) begin
            case (reg_sel)
                2'd0:    PRDATA = {27'd0, usr};
                2'd3:    PRDATA = rx_empty ? 32'd0 : {24'd0, rx_head};
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: expected APB read data and expected TX bytes are queued
// as stimulus is issued; independent monitors pop and compare when the DUT presents output.
module tb_uart_periph;

    // Divisor 3.2 MHz / (100 kBd * 16) = 2, so one bit is 32 clocks.
    localparam int unsigned BIT = 32;

    logic        PCLK;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx;
    logic        tx;

    uart_periph #(
        .CLK_FREQ  (3_200_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .rx     (rx),
        .tx     (tx)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] mask;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] exp_tx[$];
    int         checks   = 0;
    int         failures = 0;
    bit         tx_abort;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- APB read monitor ----------------
    always @(negedge PCLK) begin
        rd_exp_t e;
        if (PRESET && PSEL && !PENABLE) check("prdata_setup_phase", PRDATA, 32'd0);
        if (PRESET && PSEL && PENABLE && !PWRITE) begin
            check("pready", {31'd0, PREADY}, 32'd1);
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apb_read_unexpected: addr 0x%h data 0x%08h", PADDR, PRDATA);
            end else begin
                e = rd_q.pop_front();
                check($sformatf("apb_read_0x%h", e.addr), PRDATA & e.mask, e.exp);
            end
        end
    end

    // ---------------- TX serial monitor ----------------
    task automatic tx_wait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge PCLK);
            if (!PRESET) tx_abort = 1'b1;
        end
    endtask

    always begin : tx_monitor
        logic [7:0] b;
        logic       start_bit, stop_bit;
        @(negedge PCLK);
        if (PRESET && tx === 1'b0) begin
            tx_abort = 1'b0;
            b = 8'h00;
            tx_wait(BIT / 2);
            start_bit = tx;
            for (int i = 0; i < 8; i++) begin
                tx_wait(BIT);
                b[i] = tx;
            end
            tx_wait(BIT);
            stop_bit = tx;
            if (!tx_abort) begin
                check("tx_start_bit", {31'd0, start_bit}, 32'd0);
                check("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_byte: got 0x%02h expected none", b);
                end else begin
                    check("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, input logic [31:0] exp,
                            input logic [31:0] mask);
        rd_exp_t e;
        e.addr = a; e.mask = mask; e.exp = exp;
        rd_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic tx_send(input logic [7:0] d);
        exp_tx.push_back(d);
        apb_write(4'h8, {24'd0, d});
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(posedge PCLK); #1;
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge PCLK);
            #1 rx = d[i];
        end
        repeat (BIT) @(posedge PCLK);
        #1 rx = stop;
        repeat (BIT) @(posedge PCLK);
        #1 rx = 1'b1;
        repeat (2 * BIT) @(posedge PCLK);
    endtask

    task automatic wait_tx_drain(input int limit);
        int n = 0;
        while (exp_tx.size() != 0 && n < limit) begin
            @(posedge PCLK);
            n++;
        end
        check("tx_drain_pending", 32'(exp_tx.size()), 32'd0);
        repeat (BIT) @(posedge PCLK);
    endtask

    task automatic check_reads_done();
        repeat (2) @(posedge PCLK);
        check("reads_pending", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        logic any_low;
        PRESET = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 4'h0; PWDATA = '0; rx = 1'b1;

        // Reset state, with a read access held on the bus.
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_pready", {31'd0, PREADY}, 32'd0);
        check("reset_prdata", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);
        apb_read(4'h4, 32'h00, 32'hFFFF_FFFF);
        apb_read(4'h8, 32'h00, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h00, 32'hFFFF_FFFF);
        apb_write(4'h4, 32'hFF);
        apb_write(4'hC, 32'hFF);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);

        // 1: receive 0x3C.
        send_rx(8'h3C, 1'b1);
        apb_read(4'h0, 32'h07, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h3C, 32'hFFFF_FFFF);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);

        // 2: transmit 0xA5; busy right after the write, idle after the stop bit.
        tx_send(8'hA5);
        apb_read(4'h0, 32'h00, 32'h04);
        wait_tx_drain(20 * BIT);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);

        // 3: five quick writes fill the FIFO behind the byte in flight; a sixth is dropped.
        for (int i = 1; i <= 5; i++) tx_send(8'(i));
        apb_read(4'h0, 32'h00, 32'h02);
        apb_write(4'h8, 32'h06);
        wait_tx_drain(80 * BIT);
        repeat (12 * BIT) @(posedge PCLK);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);

        // 4: five received bytes without reading: four kept, overflow sticky until USR read.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        apb_read(4'h0, 32'h0F, 32'hFFFF_FFFF);
        apb_read(4'h0, 32'h07, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h11, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h22, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h33, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h44, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h00, 32'hFFFF_FFFF);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);

        // 5: stop bit 0 -> frame error, nothing queued.
        send_rx(8'h5A, 1'b0);
        apb_read(4'h0, 32'h16, 32'hFFFF_FFFF);
        apb_read(4'hC, 32'h00, 32'hFFFF_FFFF);
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);
        check_reads_done();

        // 6: reset in the middle of a 0x00 frame with a second byte queued.
        apb_write(4'h8, 32'h00);
        apb_write(4'h8, 32'h88);
        repeat (5 * BIT) @(posedge PCLK);
        #1;
        check("tx_low_mid_frame", {31'd0, tx}, 32'd0);
        PRESET = 1'b0;
        #1;
        check("tx_high_on_reset", {31'd0, tx}, 32'd1);
        exp_tx.delete();
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;
        apb_read(4'h0, 32'h06, 32'hFFFF_FFFF);
        any_low = 1'b0;
        repeat (12 * BIT) begin
            @(negedge PCLK);
            if (tx !== 1'b1) any_low = 1'b1;
        end
        check("tx_quiet_after_reset", {31'd0, any_low}, 32'd0);
        check_reads_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
